// File: rtl/isa_pkg.sv
// Shared MIPS subset definitions: opcodes, command kinds, field positions
// and the field-to-word encoder used when loading programs into imem.
package isa_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [2:0] {
      KIND_R   = 3'd0,
      KIND_LW  = 3'd1,
      KIND_SW  = 3'd2,
      KIND_BEQ = 3'd3,
      KIND_J   = 3'd4
   } cmd_kind_e;

   localparam int OP_LSB     = 26;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNCT_LSB  = 0;
   localparam int IMM_LSB    = 0;
   localparam int TARGET_LSB = 0;

   // Buffered entry: encoded word plus the end-of-program marker.
   typedef struct packed {
      logic        last;
      logic [31:0] word;
   } fifo_entry_t;

   // Kinds 5..7 have no encoding.
   function automatic logic is_legal_kind(input logic [2:0] kind);
      return kind <= KIND_J;
   endfunction

   // Builds the instruction word; fields a kind does not use are ignored.
   function automatic logic [31:0] encode_instr(
      input logic [2:0]  kind,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [4:0]  shamt,
      input logic [5:0]  funct,
      input logic [15:0] imm,
      input logic [25:0] target
   );
      logic [31:0] w;
      w = '0;
      case (kind)
         KIND_R: begin
            w[OP_LSB +: 6]    = OP_RTYPE;
            w[RS_LSB +: 5]    = rs;
            w[RT_LSB +: 5]    = rt;
            w[RD_LSB +: 5]    = rd;
            w[SHAMT_LSB +: 5] = shamt;
            w[FUNCT_LSB +: 6] = funct;
         end
         KIND_LW: begin
            w[OP_LSB +: 6]   = OP_LW;
            w[RS_LSB +: 5]   = rs;
            w[RT_LSB +: 5]   = rt;
            w[IMM_LSB +: 16] = imm;
         end
         KIND_SW: begin
            w[OP_LSB +: 6]   = OP_SW;
            w[RS_LSB +: 5]   = rs;
            w[RT_LSB +: 5]   = rt;
            w[IMM_LSB +: 16] = imm;
         end
         KIND_BEQ: begin
            w[OP_LSB +: 6]   = OP_BEQ;
            w[RS_LSB +: 5]   = rs;
            w[RT_LSB +: 5]   = rt;
            w[IMM_LSB +: 16] = imm;
         end
         KIND_J: begin
            w[OP_LSB +: 6]      = OP_J;
            w[TARGET_LSB +: 26] = target;
         end
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Generic synchronous FIFO with flush, full/empty flags and async
// active-low reset. Storage itself is not reset; only pointers are.
module instr_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] occ;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign full    = (occ == FULL_CNT);
   assign empty   = (occ == '0);
   assign rdata   = mem[rd_ptr];

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Write the incoming entry into the slot at the write pointer.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Advance pointers and occupancy; flush discards everything buffered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   occ <= occ + CNT_W'(1);
            2'b01:   occ <= occ - CNT_W'(1);
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Turns field-level instruction commands into MIPS words and writes them
// sequentially into instruction memory through a small decoupling buffer.
module instr_encoder
   import isa_pkg::*;
#(
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                DEPTH     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_kind,
   input  logic [4:0]        cmd_rs,
   input  logic [4:0]        cmd_rt,
   input  logic [4:0]        cmd_rd,
   input  logic [4:0]        cmd_shamt,
   input  logic [5:0]        cmd_funct,
   input  logic [15:0]       cmd_imm,
   input  logic [25:0]       cmd_target,
   input  logic              cmd_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   input  logic              imem_ready,
   output logic              done,
   output logic [15:0]       count,
   output logic              err,
   output logic [2:0]        err_kind
);

   logic        live;
   logic        full;
   logic        empty;
   logic        legal;
   logic        accept;
   logic        push;
   logic        pop;
   fifo_entry_t push_entry;
   fifo_entry_t head;

   // Commands are only taken once out of reset, with room, and not while restarting.
   assign cmd_ready  = live && !full && !start;
   assign accept     = cmd_valid && cmd_ready;
   assign legal      = is_legal_kind(cmd_kind);
   assign push       = accept && legal;
   assign pop        = !empty && imem_ready && !start;
   assign push_entry = {cmd_last, encode_instr(cmd_kind, cmd_rs, cmd_rt, cmd_rd,
                                               cmd_shamt, cmd_funct, cmd_imm, cmd_target)};

   assign imem_we    = !empty;
   assign imem_wdata = empty ? 32'd0 : head.word;

   instr_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (start),
      .push  (push),
      .wdata (push_entry),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   // Hold cmd_ready low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live <= 1'b0;
      end else begin
         live <= 1'b1;
      end
   end

   // Write address, written-word count and end-of-program pulse advance per completed write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_addr <= BASE_ADDR;
         count     <= '0;
         done      <= 1'b0;
      end else if (start) begin
         imem_addr <= BASE_ADDR;
         count     <= '0;
         done      <= 1'b0;
      end else begin
         done <= pop && head.last;
         if (pop) begin
            imem_addr <= imem_addr + ADDR_W'(4);
            if (count != 16'hFFFF) begin
               count <= count + 16'd1;
            end
         end
      end
   end

   // Sticky error flag; the kind of the first illegal command is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err      <= 1'b0;
         err_kind <= '0;
      end else if (start) begin
         err      <= 1'b0;
         err_kind <= '0;
      end else if (accept && !legal) begin
         err <= 1'b1;
         if (!err) begin
            err_kind <= cmd_kind;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: queue-based reference model,
// per-cycle compare process and directed checks on literal MIPS words.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_kind;
   logic [4:0]  cmd_rs;
   logic [4:0]  cmd_rt;
   logic [4:0]  cmd_rd;
   logic [4:0]  cmd_shamt;
   logic [5:0]  cmd_funct;
   logic [15:0] cmd_imm;
   logic [25:0] cmd_target;
   logic        cmd_last;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        imem_ready;
   logic        done;
   logic [15:0] count;
   logic        err;
   logic [2:0]  err_kind;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] word;
      logic        last;
   } exp_t;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   exp_t mq[$];
   wr_t  wlog[$];
   int   m_addr;
   int   m_count;
   logic m_err;
   logic [2:0] m_err_kind;
   logic m_done;
   logic m_live;
   int   cyc = 0;
   int   done_hits = 0;
   int   done_cyc = -1;

   instr_encoder #(
      .ADDR_W    (8),
      .BASE_ADDR (8'h00),
      .DEPTH     (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_kind   (cmd_kind),
      .cmd_rs     (cmd_rs),
      .cmd_rt     (cmd_rt),
      .cmd_rd     (cmd_rd),
      .cmd_shamt  (cmd_shamt),
      .cmd_funct  (cmd_funct),
      .cmd_imm    (cmd_imm),
      .cmd_target (cmd_target),
      .cmd_last   (cmd_last),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .imem_ready (imem_ready),
      .done       (done),
      .count      (count),
      .err        (err),
      .err_kind   (err_kind)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference encoding from the opcode table, by plain arithmetic.
   function automatic logic [31:0] modelWord(input int kind, input int rs, input int rt,
                                             input int rd, input int shamt, input int funct,
                                             input int imm, input int target);
      longint unsigned v;
      int op_tab[5] = '{0, 35, 43, 4, 2};
      v = 0;
      if (kind == 0)
         v = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + shamt * 64'd64 + funct;
      else if (kind >= 1 && kind <= 3)
         v = op_tab[kind] * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
      else if (kind == 4)
         v = op_tab[4] * 64'd67108864 + target;
      return v[31:0];
   endfunction

   // Reference model: advances on every clock edge from the observed handshakes.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_addr = 0; m_count = 0; m_err = 0; m_err_kind = 0; m_done = 0; m_live = 0;
      end else begin
         cyc++;
         if (start) begin
            mq.delete();
            m_addr = 0; m_count = 0; m_err = 0; m_err_kind = 0; m_done = 0;
         end else begin
            m_done = 0;
            if (mq.size() > 0 && imem_ready) begin
               m_done = mq[0].last;
               void'(mq.pop_front());
               m_addr = (m_addr + 4) % 256;
               if (m_count < 65535) m_count++;
            end
            if (cmd_valid && cmd_ready) begin
               if (cmd_kind <= 3'd4) begin
                  mq.push_back('{modelWord(int'(cmd_kind), int'(cmd_rs), int'(cmd_rt),
                                           int'(cmd_rd), int'(cmd_shamt), int'(cmd_funct),
                                           int'(cmd_imm), int'(cmd_target)), cmd_last});
               end else begin
                  if (!m_err) m_err_kind = cmd_kind;
                  m_err = 1;
               end
            end
         end
         m_live = 1;
      end
   end

   // Compare process: checks every output against the model on each falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("imem_we", imem_we, mq.size() != 0);
         if (mq.size() != 0) begin
            checkOutput("imem_addr", imem_addr, m_addr);
            checkOutput("imem_wdata", imem_wdata, mq[0].word);
         end
         checkOutput("cmd_ready", cmd_ready, m_live && mq.size() < 2 && !start);
         checkOutput("count", count, m_count);
         checkOutput("err", err, m_err);
         checkOutput("err_kind", err_kind, m_err_kind);
         checkOutput("done", done, m_done);
         if (done) begin
            done_hits++;
            done_cyc = cyc;
         end
         if (imem_we && imem_ready && !start)
            wlog.push_back('{imem_addr, imem_wdata, cyc});
      end
   end

   task automatic setCmd(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                         input logic [15:0] imm, input logic [25:0] target, input logic last);
      cmd_kind = kind; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_shamt = shamt;
      cmd_funct = funct; cmd_imm = imm; cmd_target = target; cmd_last = last;
      cmd_valid = 1'b1;
   endtask

   task automatic waitAccept();
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (cmd_ready) break;
      end
      if (k == 200) checkOutput("accept_timeout", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                                input logic [15:0] imm, input logic [25:0] target, input logic last);
      setCmd(kind, rs, rt, rd, shamt, funct, imm, target, last);
      waitAccept();
   endtask

   task automatic sendLw(input logic [15:0] imm, input logic last);
      applyStimulus(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, imm, 26'd0, last);
   endtask

   task automatic waitIdle();
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!imem_we) break;
      end
      if (k == 200) checkOutput("drain_timeout", imem_we, 0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic doStart();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wlog.delete();
      done_hits = 0;
      done_cyc = -1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 0; start = 0; cmd_valid = 0; imem_ready = 0;
      setCmd(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
      cmd_valid = 0;

      // Model self-pins against hand-encoded words.
      checkOutput("model_add", modelWord(0, 1, 2, 3, 0, 32, 0, 0), 32'h00221820);
      checkOutput("model_lw",  modelWord(1, 9, 8, 0, 0, 0, 4, 0),  32'h8D280004);
      checkOutput("model_sw",  modelWord(2, 9, 8, 0, 0, 0, 8, 0),  32'hAD280008);
      checkOutput("model_beq", modelWord(3, 1, 2, 0, 0, 0, 65535, 0), 32'h1022FFFF);
      checkOutput("model_j",   modelWord(4, 0, 0, 0, 0, 0, 0, 16), 32'h08000010);

      #12;
      checkOutput("rst_cmd_ready", cmd_ready, 0);
      checkOutput("rst_imem_we", imem_we, 0);
      checkOutput("rst_imem_addr", imem_addr, 0);
      checkOutput("rst_imem_wdata", imem_wdata, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_count", count, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_err_kind", err_kind, 0);
      #11 rst_n = 1;
      @(posedge clk); #1;

      // Five legal commands, memory always ready.
      $display("[TB] five-instruction program");
      imem_ready = 1;
      applyStimulus(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0);
      applyStimulus(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0);
      applyStimulus(3'd2, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'd8, 26'd0, 1'b0);
      applyStimulus(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
      applyStimulus(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1);
      waitIdle();
      checkOutput("t1_nwrites", wlog.size(), 5);
      if (wlog.size() == 5) begin
         checkOutput("t1_w0", wlog[0].data, 32'h00221820); checkOutput("t1_a0", wlog[0].addr, 8'h00);
         checkOutput("t1_w1", wlog[1].data, 32'h8D280004); checkOutput("t1_a1", wlog[1].addr, 8'h04);
         checkOutput("t1_w2", wlog[2].data, 32'hAD280008); checkOutput("t1_a2", wlog[2].addr, 8'h08);
         checkOutput("t1_w3", wlog[3].data, 32'h1022FFFF); checkOutput("t1_a3", wlog[3].addr, 8'h0C);
         checkOutput("t1_w4", wlog[4].data, 32'h08000010); checkOutput("t1_a4", wlog[4].addr, 8'h10);
      end
      checkOutput("t1_count", count, 5);
      checkOutput("t1_done_hits", done_hits, 1);

      // Backpressure: buffer fills, third command waits.
      $display("[TB] backpressure");
      doStart();
      imem_ready = 0;
      sendLw(16'd1, 1'b0);
      sendLw(16'd2, 1'b0);
      setCmd(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'd3, 26'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("t2_ready_low", cmd_ready, 0);
         checkOutput("t2_we_high", imem_we, 1);
         checkOutput("t2_addr_hold", imem_addr, 8'h00);
         checkOutput("t2_data_hold", imem_wdata, 32'h8D280001);
      end
      @(posedge clk); #1;
      imem_ready = 1;
      waitAccept();
      waitIdle();
      checkOutput("t2_nwrites", wlog.size(), 3);
      if (wlog.size() == 3) begin
         checkOutput("t2_a0", wlog[0].addr, 8'h00); checkOutput("t2_w0", wlog[0].data, 32'h8D280001);
         checkOutput("t2_a1", wlog[1].addr, 8'h04); checkOutput("t2_w1", wlog[1].data, 32'h8D280002);
         checkOutput("t2_a2", wlog[2].addr, 8'h08); checkOutput("t2_w2", wlog[2].data, 32'h8D280003);
      end

      // Illegal kinds between legal commands.
      $display("[TB] illegal kinds");
      doStart();
      applyStimulus(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0);
      applyStimulus(3'd6, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1, 1'b1);
      sendLw(16'd4, 1'b0);
      waitIdle();
      applyStimulus(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
      waitIdle();
      checkOutput("t3_err", err, 1);
      checkOutput("t3_err_kind", err_kind, 3'd6);
      checkOutput("t3_nwrites", wlog.size(), 2);
      if (wlog.size() == 2) begin
         checkOutput("t3_a0", wlog[0].addr, 8'h00); checkOutput("t3_w0", wlog[0].data, 32'h00221820);
         checkOutput("t3_a1", wlog[1].addr, 8'h04); checkOutput("t3_w1", wlog[1].data, 32'h8D280004);
      end
      checkOutput("t3_count", count, 2);
      checkOutput("t3_done_hits", done_hits, 0);

      // Address wrap after 64 words.
      $display("[TB] address wrap");
      doStart();
      for (int i = 0; i < 65; i++) sendLw(16'(i), i == 64);
      waitIdle();
      checkOutput("t4_nwrites", wlog.size(), 65);
      if (wlog.size() == 65) begin
         checkOutput("t4_a63", wlog[63].addr, 8'hFC);
         checkOutput("t4_a64", wlog[64].addr, 8'h00);
         checkOutput("t4_w64", wlog[64].data, 32'h8D280040);
         checkOutput("t4_done_cyc", done_cyc, wlog[64].cyc + 1);
      end
      checkOutput("t4_count", count, 65);
      checkOutput("t4_done_hits", done_hits, 1);

      // Restart with two words buffered and memory stalled.
      $display("[TB] restart with pending words");
      doStart();
      sendLw(16'd1, 1'b0);
      waitIdle();
      imem_ready = 0;
      applyStimulus(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
      sendLw(16'd2, 1'b0);
      sendLw(16'd3, 1'b1);
      @(negedge clk);
      checkOutput("t5_pre_count", count, 1);
      checkOutput("t5_pre_err", err, 1);
      checkOutput("t5_pre_we", imem_we, 1);
      @(posedge clk); #1;
      setCmd(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0);
      start = 1;
      @(negedge clk);
      checkOutput("t5_ready_in_start", cmd_ready, 0);
      @(posedge clk); #1;
      start = 0; cmd_valid = 0;
      @(negedge clk);
      checkOutput("t5_we", imem_we, 0);
      checkOutput("t5_addr", imem_addr, 8'h00);
      checkOutput("t5_count", count, 0);
      checkOutput("t5_err", err, 0);
      imem_ready = 1;
      repeat (3) @(negedge clk);
      checkOutput("t5_nothing_written", imem_we, 0);
      @(posedge clk); #1;

      // Asynchronous reset mid-stream.
      $display("[TB] asynchronous reset");
      sendLw(16'd7, 1'b0);
      waitIdle();
      applyStimulus(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
      imem_ready = 0;
      sendLw(16'd5, 1'b0);
      sendLw(16'd6, 1'b0);
      @(posedge clk); #2;
      rst_n = 0;
      #1;
      checkOutput("t6_we", imem_we, 0);
      checkOutput("t6_addr", imem_addr, 8'h00);
      checkOutput("t6_wdata", imem_wdata, 0);
      checkOutput("t6_count", count, 0);
      checkOutput("t6_ready", cmd_ready, 0);
      checkOutput("t6_done", done, 0);
      checkOutput("t6_err", err, 0);
      checkOutput("t6_err_kind", err_kind, 0);
      @(posedge clk); #2;
      rst_n = 1;
      wlog.delete();
      @(posedge clk); #1;
      imem_ready = 1;
      sendLw(16'd8, 1'b0);
      waitIdle();
      checkOutput("t6_nwrites", wlog.size(), 1);
      if (wlog.size() == 1) begin
         checkOutput("t6_a0", wlog[0].addr, 8'h00);
         checkOutput("t6_w0", wlog[0].data, 32'h8D280008);
      end
      checkOutput("t6_count_after", count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Reverse direction of the main decoder: turns field-level instruction commands into 32-bit MIPS words and writes them sequentially into instruction memory.
- Used by the testbench/boot path to load programs without hex files.
- Supports the same instruction set as the decoder: R-type, LW, SW, BEQ, J.
- Structure: valid/ready command input, 2-deep buffer, write port with backpressure, wrapping byte-address counter.

Parameters:
- ADDR_W, 8, byte-address width of imem port; address wraps modulo 2^ADDR_W.
- BASE_ADDR, 0, first write address after reset/start; must be a multiple of 4.
- DEPTH, 2, buffer entries between command accept and memory write.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  synchronous restart: flush buffer, address:=BASE_ADDR, count:=0, err cleared
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_kind  in  3  0=R,1=LW,2=SW,3=BEQ,4=J,5-7 illegal
- cmd_rs, cmd_rt, cmd_rd, cmd_shamt  in  5 each  register/shift fields
- cmd_funct  in  6  R-type function code
- cmd_imm  in  16  immediate/offset (LW/SW/BEQ)
- cmd_target  in  26  jump target (J)
- cmd_last  in  1  marks final instruction of program
- imem_we  out  1  write request
- imem_addr  out  ADDR_W  byte address of write
- imem_wdata  out  32  encoded instruction
- imem_ready  in  1  write completes when imem_we&&imem_ready
- done  out  1  one-cycle pulse when the cmd_last word is written
- count  out  16  instructions written since reset/start, saturates at 0xFFFF
- err  out  1  sticky: illegal cmd_kind seen
- err_kind  out  3  cmd_kind of first illegal command

Behaviour:
- Reset values:
  - cmd_ready=0 during reset, 1 from the first cycle after rst_n rises.
  - imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, done=0, count=0, err=0, err_kind=0.
- Encoding is combinational at accept; the encoded word plus its last flag are stored in the buffer.
  - R: {000000,rs,rt,rd,shamt,funct}
  - LW: {100011,rs,rt,imm}
  - SW: {101011,rs,rt,imm}
  - BEQ: {000100,rs,rt,imm}
  - J: {000010,target}
  - Fields not used by a kind are ignored.
- cmd_ready = !full && !start. Accept at edge N: imem_we is high at N+1 at the earliest. No combinational path from cmd_* to imem_*.
- imem_we = !empty. imem_wdata and imem_addr are the buffer head and the current address, held stable while imem_ready=0.
- On each write (imem_we&&imem_ready):
  - pop the head;
  - imem_addr += 4, wrapping modulo 2^ADDR_W;
  - count += 1, saturating;
  - done=1 next cycle if head.last.
- Illegal kind:
  - Accepted (ready follows the normal rule) but not pushed.
  - err=1; err_kind captured only if err was 0.
  - Address and count unchanged; a cmd_last on an illegal command produces no done.
- Simultaneous push and pop when full: not allowed, since cmd_ready=0 when full. Push and pop in the same cycle when partially full keeps occupancy unchanged.
- start has priority over accept and write in the same cycle: the buffer is emptied, that cycle's write is not counted, and done is cleared.
- rst_n low mid-operation: everything returns to reset values asynchronously and pending words are lost.

Decomposition:
- Package isa_pkg:
  - opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_J=6'b000010;
  - cmd_kind encoding constants KIND_R..KIND_J;
  - field position constants.
  - Shared with the decoder.
- Sub-module instr_fifo: generic synchronous FIFO, WIDTH=33 (word+last), DEPTH parameter, full/empty flags, async active-low reset.

Test Plan:
- Five legal commands, imem_ready=1 → writes in order:
  - add $3,$1,$2 (funct 0x20) → 0x00221820 @0x00
  - lw $8,4($9) → 0x8D280004 @0x04
  - sw $8,8($9) → 0xAD280008 @0x08
  - beq $1,$2,0xFFFF → 0x1022FFFF @0x0C
  - j 0x10 → 0x08000010 @0x10
  - count=5 at the end.
- Backpressure: imem_ready=0, drive 3 valid commands → 2 accepted, then cmd_ready=0 with imem_we=1 and data/addr stable. Raise imem_ready → 2 writes @0x00, 0x04, then the third is accepted.
- Illegal kind=6 between two legal commands → err=1, err_kind=6, no write for it, legal words at consecutive addresses 0x00, 0x04. A second illegal kind=7 leaves err_kind=6.
- Wrap: ADDR_W=8, 65 legal writes → 64th @0xFC, 65th @0x00, count=65. cmd_last on the 65th → done high exactly 1 cycle after that write.
- start asserted with 2 words buffered and imem_ready=0 → next cycle imem_we=0, addr=BASE_ADDR, count=0, err=0. The cmd offered during start is not accepted.
- rst_n pulsed low mid-stream (asynchronous, between edges) → outputs at reset values immediately; after release the first write goes to 0x00.
